up_core: RTL and testbench

// - Minimal 8-bit accumulator microprocessor: internal program ROM, 16x8 register file, one level-sensitive interrupt.
// - Self-contained top-level CPU; one instruction per clock.
// - Debug outputs expose architectural state for verification.

---
 rtl/up_pkg.sv | 29 ++
 rtl/up_alu.sv | 39 +++
 rtl/up_core.sv | 134 +++++++++++++
 tb/tb_up_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// Shared definitions for the up_core accumulator CPU: widths, opcodes and core state.
package up_pkg;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int AW = 8;
    localparam int RW = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_EI   = 4'hC;
    localparam logic [3:0] OP_DI   = 4'hD;
    localparam logic [3:0] OP_RETI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;
endpackage

// File: rtl/up_alu.sv
// Combinational ALU: loads, add/sub with carry/borrow, bitwise logic, zero detect.
module up_alu
    import up_pkg::*;
(
    input  logic [3:0]    op,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] operand,
    input  logic          c_in,
    output logic [DW-1:0] result,
    output logic          c_out,
    output logic          z_out
);
    logic [DW:0] sum;

    always_comb begin
        sum    = '0;
        result = acc;
        c_out  = c_in;
        case (op)
            OP_LDI, OP_LD: result = operand;
            OP_ADD: begin
                sum    = {1'b0, acc} + {1'b0, operand};
                result = sum[DW-1:0];
                c_out  = sum[DW];
            end
            // the ninth bit of a widened subtract is the borrow
            OP_SUB: begin
                sum    = {1'b0, acc} - {1'b0, operand};
                result = sum[DW-1:0];
                c_out  = sum[DW];
            end
            OP_AND:  result = acc & operand;
            OP_OR:   result = acc | operand;
            OP_XOR:  result = acc ^ operand;
            default: result = acc;
        endcase
        z_out = (result == '0);
    end
endmodule

// File: rtl/up_core.sv
// 8-bit accumulator CPU: one instruction per clock, 16x8 register file, single level interrupt.
// state   | meaning
// ST_RUN  | fetch/execute one instruction per edge
// ST_HALT | HLT executed, pc frozen, waits for an enabled interrupt
module up_core
    import up_pkg::*;
#(
    parameter logic [AW-1:0]     INT_VEC   = 8'hF0,
    parameter logic [IW*256-1:0] ROM_IMAGE = '0
)
(
    input  logic          clk,
    input  logic          nRst,
    input  logic          intr,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [2:0]    flags,
    output logic          halted
);
    state_t        state, state_nxt;
    logic          ie, c, z;
    logic [AW-1:0] saved_pc;
    logic [1:0]    saved_zc;
    logic [DW-1:0] rf [16];

    logic [IW-1:0] instr;
    logic [3:0]    op;
    logic [RW-1:0] r;
    logic [DW-1:0] k, operand, alu_result;
    logic          alu_c, alu_z, take_int, rf_we;

    logic [AW-1:0] pc_nxt, spc_nxt;
    logic [DW-1:0] acc_nxt;
    logic          ie_nxt, c_nxt, z_nxt;
    logic [1:0]    szc_nxt;

    // ROM is an elaboration-time constant image, read combinationally at pc
    assign instr    = ROM_IMAGE[{pc, 4'b0000} +: IW];
    assign op       = instr[15:12];
    assign r        = instr[11:8];
    assign k        = instr[7:0];
    assign operand  = (op == OP_LDI) ? k : rf[r];
    assign take_int = intr & ie;

    up_alu u_alu (
        .op      (op),
        .acc     (acc),
        .operand (operand),
        .c_in    (c),
        .result  (alu_result),
        .c_out   (alu_c),
        .z_out   (alu_z)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (take_int)                              state_nxt = ST_RUN;
        else if (state == ST_RUN && op == OP_HLT)  state_nxt = ST_HALT;
    end

    always_comb begin
        pc_nxt  = pc;
        acc_nxt = acc;
        c_nxt   = c;
        z_nxt   = z;
        ie_nxt  = ie;
        spc_nxt = saved_pc;
        szc_nxt = saved_zc;
        rf_we   = 1'b0;
        if (take_int) begin
            // a halted core resumes after the HLT, otherwise the discarded instruction is replayed
            spc_nxt = (state == ST_HALT) ? pc + 8'd1 : pc;
            szc_nxt = {c, z};
            ie_nxt  = 1'b0;
            pc_nxt  = INT_VEC;
        end else if (state == ST_RUN) begin
            pc_nxt = pc + 8'd1;
            case (op)
                OP_LDI, OP_LD, OP_AND, OP_OR, OP_XOR: begin
                    acc_nxt = alu_result;
                    z_nxt   = alu_z;
                end
                OP_ADD, OP_SUB: begin
                    acc_nxt = alu_result;
                    z_nxt   = alu_z;
                    c_nxt   = alu_c;
                end
                OP_ST:  rf_we = 1'b1;
                OP_JMP: pc_nxt = k;
                OP_JZ:  if (z) pc_nxt = k;
                OP_JC:  if (c) pc_nxt = k;
                OP_EI:  ie_nxt = 1'b1;
                OP_DI:  ie_nxt = 1'b0;
                OP_RETI: begin
                    pc_nxt         = saved_pc;
                    {c_nxt, z_nxt} = saved_zc;
                    ie_nxt         = 1'b1;
                end
                OP_HLT:  pc_nxt = pc;
                default: pc_nxt = pc + 8'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pc       <= '0;
            acc      <= '0;
            c        <= 1'b0;
            z        <= 1'b0;
            ie       <= 1'b0;
            saved_pc <= '0;
            saved_zc <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            pc       <= pc_nxt;
            acc      <= acc_nxt;
            c        <= c_nxt;
            z        <= z_nxt;
            ie       <= ie_nxt;
            saved_pc <= spc_nxt;
            saved_zc <= szc_nxt;
            if (rf_we) rf[r] <= acc;
        end
    end

    assign flags  = {ie, c, z};
    assign halted = (state == ST_HALT);
endmodule

// File: tb/tb_up_core.sv
// Bench for up_core: directed program sections plus randomized interrupt/reset lockstep against an ISS.
module tb_up_core;
    function automatic logic [4095:0] build_rom();
        logic [4095:0] img;
        logic [31:0]   s;
        img = '0;
        s   = 32'h1234_5678;
        for (int a = 0; a < 256; a++) begin
            s = s * 32'd1103515245 + 32'd12345;
            img[a*16 +: 16] = s[31:16];
        end
        img['h00*16 +: 16] = 16'h0000;
        img['h01*16 +: 16] = 16'h0000;
        img['h02*16 +: 16] = 16'h0000;
        img['h03*16 +: 16] = 16'hC000;
        img['h04*16 +: 16] = 16'h0000;
        img['h05*16 +: 16] = 16'h103C;
        img['h06*16 +: 16] = 16'hD000;
        img['h07*16 +: 16] = 16'h10FF;
        img['h08*16 +: 16] = 16'h3100;
        img['h09*16 +: 16] = 16'h1001;
        img['h0A*16 +: 16] = 16'h4100;
        img['h0B*16 +: 16] = 16'h5100;
        img['h0C*16 +: 16] = 16'h1000;
        img['h0D*16 +: 16] = 16'hA020;
        img['h10*16 +: 16] = 16'hF000;
        img['h20*16 +: 16] = 16'h3200;
        img['h21*16 +: 16] = 16'h4200;
        img['h22*16 +: 16] = 16'hB050;
        img['h23*16 +: 16] = 16'hC000;
        img['h24*16 +: 16] = 16'h9010;
        img['hF0*16 +: 16] = 16'h1000;
        img['hF1*16 +: 16] = 16'hE000;
        return img;
    endfunction

    localparam logic [4095:0] ROM = build_rom();

    logic       clk, nRst, intr;
    logic [7:0] pc, acc;
    logic [2:0] flags;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mpc, macc, mspc;
    logic       mz, mc, mie, mhalt;
    logic [1:0] mszc;
    logic [7:0] mR [16];

    up_core #(.INT_VEC(8'hF0), .ROM_IMAGE(ROM)) dut (
        .clk    (clk),
        .nRst   (nRst),
        .intr   (intr),
        .pc     (pc),
        .acc    (acc),
        .flags  (flags),
        .halted (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic m_reset();
        mpc = 0; macc = 0; mspc = 0; mz = 0; mc = 0; mie = 0; mhalt = 0; mszc = 0;
        for (int i = 0; i < 16; i++) mR[i] = 0;
    endtask

    // instruction-level reference: one architectural step per rising edge
    task automatic m_edge();
        logic [15:0] w;
        logic [3:0]  op, r;
        logic [7:0]  k, b, nxt;
        int          t;
        if (!nRst) return;
        w  = ROM[{mpc, 4'b0000} +: 16];
        op = w[15:12]; r = w[11:8]; k = w[7:0]; b = mR[r];
        if (intr && mie) begin
            mspc  = mhalt ? mpc + 8'd1 : mpc;
            mszc  = {mc, mz};
            mie   = 0;
            mhalt = 0;
            mpc   = 8'hF0;
        end else if (!mhalt) begin
            nxt = mpc + 8'd1;
            case (op)
                4'h1: macc = k;
                4'h2: macc = b;
                4'h3: mR[r] = macc;
                4'h4: begin t = int'(macc) + int'(b); mc = (t > 255); macc = 8'(t % 256); end
                4'h5: begin mc = (macc < b); macc = macc - b; end
                4'h6: macc = macc & b;
                4'h7: macc = macc | b;
                4'h8: macc = macc ^ b;
                4'h9: nxt = k;
                4'hA: if (mz) nxt = k;
                4'hB: if (mc) nxt = k;
                4'hC: mie = 1;
                4'hD: mie = 0;
                4'hE: begin nxt = mspc; {mc, mz} = mszc; mie = 1; end
                4'hF: begin mhalt = 1; nxt = mpc; end
                default: ;
            endcase
            if (op == 4'h1 || op == 4'h2 || (op >= 4'h4 && op <= 4'h8)) mz = (macc == 8'h00);
            mpc = nxt;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0; intr = 1'b0;
        m_reset();
        repeat (10) @(negedge clk);
        n_checks++; if (pc !== 8'h00)    begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
        n_checks++; if (acc !== 8'h00)   begin n_fail++; $display("FAIL reset_acc got %h want 00", acc); end
        n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", flags); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        nRst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_checks++;
            if (pc !== 8'(i)) begin n_fail++; $display("FAIL nop_seq pc got %h want %h", pc, 8'(i)); end
        end
        cycle();
        n_checks++; if (flags !== 3'b100) begin n_fail++; $display("FAIL ei_flags got %b want 100", flags); end
    endtask

    task automatic test_interrupt();
        cycle();
        n_checks++; if (pc !== 8'h05) begin n_fail++; $display("FAIL int_pre_pc got %h want 05", pc); end
        intr = 1'b1;
        cycle();
        intr = 1'b0;
        n_checks++; if (pc !== 8'hF0) begin n_fail++; $display("FAIL int_vector pc got %h want f0", pc); end
        n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL int_entry_flags got %b want 000", flags); end
        cycle();
        n_checks++; if (flags !== 3'b001) begin n_fail++; $display("FAIL handler_flags got %b want 001", flags); end
        cycle();
        n_checks++; if (pc !== 8'h05) begin n_fail++; $display("FAIL reti_pc got %h want 05", pc); end
        n_checks++; if (flags !== 3'b100) begin n_fail++; $display("FAIL reti_flags got %b want 100", flags); end
        cycle();
        n_checks++; if (acc !== 8'h3C) begin n_fail++; $display("FAIL replay_acc got %h want 3c", acc); end
        cycle();
        n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL di_flags got %b want 000", flags); end
    endtask

    // interrupt held high while ie=0 through the arithmetic and branch sections
    task automatic test_arith();
        logic [7:0] ep [5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        logic [7:0] ea [5] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01};
        logic [2:0] ef [5] = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
        intr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if ({pc, acc, flags} !== {ep[i], ea[i], ef[i]})
                begin n_fail++; $display("FAIL arith_step%0d pc/acc/flags got %h/%h/%b want %h/%h/%b", i, pc, acc, flags, ep[i], ea[i], ef[i]); end
        end
    endtask

    task automatic test_branch();
        logic [7:0] ep [5] = '{8'h0D, 8'h20, 8'h21, 8'h22, 8'h23};
        logic [2:0] ef [5] = '{3'b011, 3'b011, 3'b011, 3'b001, 3'b001};
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if ({pc, flags} !== {ep[i], ef[i]})
                begin n_fail++; $display("FAIL branch_step%0d pc/flags got %h/%b want %h/%b", i, pc, flags, ep[i], ef[i]); end
        end
        intr = 1'b0;
    endtask

    task automatic test_halt_wake();
        cycle();
        cycle();
        n_checks++; if (pc !== 8'h10) begin n_fail++; $display("FAIL jmp_pc got %h want 10", pc); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({pc, halted} !== {8'h10, 1'b1}) begin n_fail++; $display("FAIL halt_hold pc/halted got %h/%b want 10/1", pc, halted); end
        end
        intr = 1'b1;
        cycle();
        intr = 1'b0;
        n_checks++;
        if ({pc, halted, flags[2]} !== {8'hF0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL wake pc/halted/ie got %h/%b/%b want f0/0/0", pc, halted, flags[2]); end
        cycle();
        cycle();
        n_checks++;
        if ({pc, flags} !== {8'h11, 3'b101}) begin n_fail++; $display("FAIL wake_reti pc/flags got %h/%b want 11/101", pc, flags); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            intr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) begin
                nRst = 1'b0;
                m_reset();
                #1;
                n_checks++;
                if ({pc, acc, flags, halted} !== 20'h0)
                    begin n_fail++; $display("FAIL async_reset pc/acc/flags/halted got %h/%h/%b/%b want 0", pc, acc, flags, halted); end
                cycle();
                nRst = 1'b1;
            end
            cycle();
            n_checks++;
            if ({pc, acc, flags, halted} !== {mpc, macc, mie, mc, mz, mhalt})
                begin n_fail++; $display("FAIL lockstep cyc%0d pc/acc/flags/halted got %h/%h/%b/%b want %h/%h/%b/%b",
                                         n, pc, acc, flags, halted, mpc, macc, {mie, mc, mz}, mhalt); end
        end
        intr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_arith();
        test_branch();
        test_halt_wake();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
